// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM: one shared period counter, per-channel double-buffered duty/dir, registered fwd/rev legs.
// Build option: define PWM_SOFT_START_EN to ramp duty by RAMP_STEP per period instead of jumping.

module pwm_multi_channel_lane #(
  parameter int WIDTH     = 12,
  parameter int RAMP_STEP = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             activ,
  input  logic             boundary,
  input  logic [WIDTH-1:0] cnt,
  input  logic             load,
  input  logic [WIDTH-1:0] duty_in,
  input  logic             dir_in,
  output logic             pwm_fwd,
  output logic             pwm_rev
);

  if (RAMP_STEP < 1) begin : g_bad_step
    $error("RAMP_STEP must be at least 1");
  end

  logic [WIDTH-1:0] pend_duty_q, pend_duty_d;
  logic             pend_dir_q, pend_dir_d;
  logic             pend_vld_q, pend_vld_d;
  logic [WIDTH-1:0] act_duty_q, act_duty_d;
  logic             act_dir_q, act_dir_d;
  logic             fwd_q, fwd_d;
  logic             rev_q, rev_d;
  logic             raw;

`ifdef PWM_SOFT_START_EN
  localparam logic [WIDTH-1:0] STEP = WIDTH'(RAMP_STEP);
  logic [WIDTH-1:0] tgt_duty_q, tgt_duty_d;
  logic             tgt_dir_q, tgt_dir_d;
`endif

  always_comb begin
    pend_duty_d = pend_duty_q;
    pend_dir_d  = pend_dir_q;
    pend_vld_d  = pend_vld_q;
    act_duty_d  = act_duty_q;
    act_dir_d   = act_dir_q;
    // A load in the boundary cycle itself must be seen by that boundary.
    if (load) begin
      pend_duty_d = duty_in;
      pend_dir_d  = dir_in;
      pend_vld_d  = 1'b1;
    end
`ifdef PWM_SOFT_START_EN
    tgt_duty_d = tgt_duty_q;
    tgt_dir_d  = tgt_dir_q;
    if (boundary && pend_vld_d) begin
      tgt_duty_d = pend_duty_d;
      tgt_dir_d  = pend_dir_d;
      pend_vld_d = 1'b0;
    end
    if (!activ) begin
      act_duty_d = '0;
    end else if (boundary) begin
      if (tgt_dir_d != act_dir_q) begin
        // Ramp down first; the leg only swaps once duty has reached zero.
        act_duty_d = (act_duty_q > STEP) ? act_duty_q - STEP : '0;
        if (act_duty_d == '0) act_dir_d = tgt_dir_d;
      end else if (act_duty_q < tgt_duty_d) begin
        act_duty_d = (tgt_duty_d - act_duty_q > STEP) ? act_duty_q + STEP : tgt_duty_d;
      end else begin
        act_duty_d = (act_duty_q - tgt_duty_d > STEP) ? act_duty_q - STEP : tgt_duty_d;
      end
    end
`else
    if (boundary && pend_vld_d) begin
      act_duty_d = pend_duty_d;
      act_dir_d  = pend_dir_d;
      pend_vld_d = 1'b0;
    end
`endif
  end

  always_comb begin
    raw   = cnt < act_duty_q;
    fwd_d = activ & raw & ~act_dir_q;
    rev_d = activ & raw & act_dir_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pend_duty_q <= '0;
      pend_dir_q  <= 1'b0;
      pend_vld_q  <= 1'b0;
      act_duty_q  <= '0;
      act_dir_q   <= 1'b0;
      fwd_q       <= 1'b0;
      rev_q       <= 1'b0;
    end else begin
      pend_duty_q <= pend_duty_d;
      pend_dir_q  <= pend_dir_d;
      pend_vld_q  <= pend_vld_d;
      act_duty_q  <= act_duty_d;
      act_dir_q   <= act_dir_d;
      fwd_q       <= fwd_d;
      rev_q       <= rev_d;
    end
  end

`ifdef PWM_SOFT_START_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      tgt_duty_q <= '0;
      tgt_dir_q  <= 1'b0;
    end else begin
      tgt_duty_q <= tgt_duty_d;
      tgt_dir_q  <= tgt_dir_d;
    end
  end
`endif

  assign pwm_fwd = fwd_q;
  assign pwm_rev = rev_q;

endmodule

module pwm_multi_channel #(
  parameter int N_CH      = 2,
  parameter int WIDTH     = 12,
  parameter int PERIOD    = 1000,
  parameter int RAMP_STEP = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  activ,
  input  logic [N_CH-1:0]       load,
  input  logic [N_CH*WIDTH-1:0] duty_in,
  input  logic [N_CH-1:0]       dir_in,
  output logic [N_CH-1:0]       pwm_fwd,
  output logic [N_CH-1:0]       pwm_rev,
  output logic                  period_start,
  output logic [WIDTH-1:0]      cnt_out
);

  if (PERIOD < 2 || PERIOD > (2 ** WIDTH)) begin : g_bad_period
    $error("PERIOD must lie in 2..2**WIDTH");
  end

  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(PERIOD - 1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             ps_q, ps_d;
  logic             boundary;

  always_comb begin
    boundary = activ && (cnt_q == CNT_MAX);
    if (!activ)        cnt_d = '0;
    else if (boundary) cnt_d = '0;
    else               cnt_d = cnt_q + 1'b1;
    // Flags the output cycle computed from cnt==0, aligned with the pwm registers.
    ps_d = activ && (cnt_q == '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      ps_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ps_q  <= ps_d;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_lane
    pwm_multi_channel_lane #(
      .WIDTH     (WIDTH),
      .RAMP_STEP (RAMP_STEP)
    ) u_lane (
      .clock    (clock),
      .reset    (reset),
      .activ    (activ),
      .boundary (boundary),
      .cnt      (cnt_q),
      .load     (load[k]),
      .duty_in  (duty_in[k*WIDTH +: WIDTH]),
      .dir_in   (dir_in[k]),
      .pwm_fwd  (pwm_fwd[k]),
      .pwm_rev  (pwm_rev[k])
    );
  end

  assign period_start = ps_q;
  assign cnt_out      = cnt_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Bench for pwm_multi_channel: directed scenarios plus random loads/activ toggles checked against a reference model.
module tb_pwm_multi_channel;
  localparam int N_CH = 2, WIDTH = 12, PERIOD = 1000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        activ = 1'b0;
  logic [1:0]  load = '0;
  logic [23:0] duty_in = '0;
  logic [1:0]  dir_in = '0;
  logic [1:0]  pwm_fwd, pwm_rev;
  logic        period_start;
  logic [11:0] cnt_out;

  int total = 0, bad = 0;
  bit mon_en = 0;

  pwm_multi_channel #(.N_CH(N_CH), .WIDTH(WIDTH), .PERIOD(PERIOD), .RAMP_STEP(8)) dut (
    .clock(clock), .reset(reset), .activ(activ), .load(load), .duty_in(duty_in),
    .dir_in(dir_in), .pwm_fwd(pwm_fwd), .pwm_rev(pwm_rev),
    .period_start(period_start), .cnt_out(cnt_out));

  always #10 clock = ~clock;

  // Reference model: the duty/dir in force for a period, applied at the period's last count.
  int         m_cnt = 0;
  int         m_duty[2], m_pduty[2];
  bit         m_dir[2], m_pdir[2], m_pv[2];
  logic [1:0] e_fwd = '0, e_rev = '0;
  logic       e_ps = 1'b0;

  always @(posedge clock) begin
    if (reset) begin
      m_cnt = 0; e_fwd = '0; e_rev = '0; e_ps = 1'b0;
      for (int k = 0; k < 2; k++) begin m_duty[k] = 0; m_dir[k] = 0; m_pv[k] = 0; end
    end else begin
      e_ps = activ && (m_cnt == 0);
      for (int k = 0; k < 2; k++) begin
        e_fwd[k] = activ && (m_cnt < m_duty[k]) && !m_dir[k];
        e_rev[k] = activ && (m_cnt < m_duty[k]) && m_dir[k];
        if (load[k]) begin
          m_pduty[k] = int'(duty_in[k*12 +: 12]); m_pdir[k] = dir_in[k]; m_pv[k] = 1;
        end
        if (activ && m_cnt == PERIOD - 1 && m_pv[k]) begin
          m_duty[k] = m_pduty[k]; m_dir[k] = m_pdir[k]; m_pv[k] = 0;
        end
      end
      m_cnt = activ ? (m_cnt + 1) % PERIOD : 0;
    end
  end

  always @(negedge clock) if (mon_en) begin
`ifndef PWM_SOFT_START_EN
    total++; if (pwm_fwd !== e_fwd) begin bad++; $display("FAIL model_fwd t=%0t got=%b want=%b", $time, pwm_fwd, e_fwd); end
    total++; if (pwm_rev !== e_rev) begin bad++; $display("FAIL model_rev t=%0t got=%b want=%b", $time, pwm_rev, e_rev); end
    total++; if (period_start !== e_ps) begin bad++; $display("FAIL model_ps t=%0t got=%b want=%b", $time, period_start, e_ps); end
    total++; if (cnt_out !== 12'(m_cnt)) begin bad++; $display("FAIL model_cnt t=%0t got=%0d want=%0d", $time, cnt_out, m_cnt); end
`endif
    total++; if ((pwm_fwd & pwm_rev) !== 2'b00) begin bad++; $display("FAIL exclusive t=%0t fwd=%b rev=%b want no overlap", $time, pwm_fwd, pwm_rev); end
  end

  task automatic do_load(input logic [1:0] mask, input int d0, input int d1, input logic [1:0] dr);
    load = mask; duty_in = {12'(d1), 12'(d0)}; dir_in = dr;
    @(negedge clock); load = '0;
  endtask

  task automatic sync_ps(output bit ok);
    int n = 0;
    do begin @(negedge clock); n++; end while (period_start !== 1'b1 && n < 3000);
    ok = (period_start === 1'b1);
  endtask

  // Called on the period_start cycle; counts high cycles until the next period_start.
  task automatic meas(output int f0, output int f1, output int r0, output int r1, output int len);
    f0 = 0; f1 = 0; r0 = 0; r1 = 0; len = 0;
    do begin
      f0 += int'(pwm_fwd[0]); f1 += int'(pwm_fwd[1]);
      r0 += int'(pwm_rev[0]); r1 += int'(pwm_rev[1]);
      len++; @(negedge clock);
    end while (period_start !== 1'b1 && len < 3000);
  endtask

  task automatic test_reset();
    reset = 1'b1; activ = 1'b0; load = '0;
    repeat (3) @(negedge clock);
    total++; if ({pwm_fwd, pwm_rev, period_start} !== 5'b0 || cnt_out !== 12'd0) begin
      bad++; $display("FAIL reset_state got=%b/%0d want=0/0", {pwm_fwd, pwm_rev, period_start}, cnt_out); end
    reset = 1'b0; mon_en = 1;
    @(negedge clock);
    total++; if ({pwm_fwd, pwm_rev, period_start} !== 5'b0) begin
      bad++; $display("FAIL idle_after_reset got=%b want=0", {pwm_fwd, pwm_rev, period_start}); end
  endtask

  task automatic test_duty_250();
    bit ok; int f0, f1, r0, r1, len;
    activ = 1'b1;
    do_load(2'b11, 250, 250, 2'b00);
    sync_ps(ok);
    total++; if (!ok) begin bad++; $display("FAIL d250_sync got=timeout want=period_start"); end
    for (int p = 0; p < 2; p++) begin
      meas(f0, f1, r0, r1, len);
      total++; if (f0 != 250 || f1 != 250) begin bad++; $display("FAIL d250_high got=%0d,%0d want=250", f0, f1); end
      total++; if (r0 != 0 || r1 != 0) begin bad++; $display("FAIL d250_rev got=%0d,%0d want=0", r0, r1); end
      total++; if (len != PERIOD) begin bad++; $display("FAIL d250_period got=%0d want=%0d", len, PERIOD); end
    end
  endtask

  task automatic test_mid_load();
    int f, len, rises, f0, f1, r0, r1; logic prev;
    f = 0; len = 0; rises = 0; prev = pwm_fwd[0];
    do begin
      if (pwm_fwd[0] && !prev) rises++;
      prev = pwm_fwd[0]; f += int'(pwm_fwd[0]); len++;
      if (cnt_out == 12'd400) begin load = 2'b01; duty_in = {12'd250, 12'd600}; end
      else load = '0;
      @(negedge clock);
    end while (period_start !== 1'b1 && len < 3000);
    load = '0;
    total++; if (f != 250) begin bad++; $display("FAIL midload_cur got=%0d want=250", f); end
    total++; if (rises != 0) begin bad++; $display("FAIL midload_glitch got=%0d edges want=0", rises); end
    meas(f0, f1, r0, r1, len);
    total++; if (f0 != 600 || f1 != 250) begin bad++; $display("FAIL midload_next got=%0d,%0d want=600,250", f0, f1); end
  endtask

  task automatic test_extremes();
    bit ok; int f0, f1, r0, r1, len;
    do_load(2'b11, 0, 1000, 2'b00);
    sync_ps(ok);
    for (int p = 0; p < 2; p++) begin
      meas(f0, f1, r0, r1, len);
      total++; if (f0 != 0 || f1 != PERIOD || len != PERIOD) begin
        bad++; $display("FAIL ext_0_1000 got=%0d,%0d len=%0d want=0,1000 len=1000", f0, f1, len); end
    end
    do_load(2'b11, 4095, 0, 2'b00);
    sync_ps(ok);
    for (int p = 0; p < 2; p++) begin
      meas(f0, f1, r0, r1, len);
      total++; if (f0 != PERIOD || f1 != 0 || len != PERIOD) begin
        bad++; $display("FAIL ext_4095_0 got=%0d,%0d len=%0d want=1000,0 len=1000", f0, f1, len); end
    end
  endtask

  task automatic test_dir_toggle();
    bit ok; int f0, f1, r0, r1, len;
    do_load(2'b01, 500, 0, 2'b00);
    sync_ps(ok);
    meas(f0, f1, r0, r1, len);
    total++; if (f0 != 500 || r0 != 0) begin bad++; $display("FAIL dir_fwd got=%0d/%0d want=500/0", f0, r0); end
    do_load(2'b01, 500, 0, 2'b01);
    sync_ps(ok);
    meas(f0, f1, r0, r1, len);
    total++; if (f0 != 0 || r0 != 500) begin bad++; $display("FAIL dir_rev got=%0d/%0d want=0/500", f0, r0); end
  endtask

  task automatic test_activ_drop();
    int n = 0, f0, f1, r0, r1, len;
    while (cnt_out !== 12'd123 && n < 3000) begin @(negedge clock); n++; end
    total++; if (cnt_out !== 12'd123) begin bad++; $display("FAIL drop_find got=%0d want=123", cnt_out); end
    activ = 1'b0;
    @(negedge clock);
    total++; if ({pwm_fwd, pwm_rev} !== 4'b0 || cnt_out !== 12'd0) begin
      bad++; $display("FAIL drop_outputs got=%b cnt=%0d want=0 cnt=0", {pwm_fwd, pwm_rev}, cnt_out); end
    do_load(2'b10, 0, 300, 2'b00);
    repeat (5) @(negedge clock);
    total++; if ({pwm_fwd, pwm_rev, period_start} !== 5'b0 || cnt_out !== 12'd0) begin
      bad++; $display("FAIL drop_hold got=%b cnt=%0d want=0", {pwm_fwd, pwm_rev, period_start}, cnt_out); end
    activ = 1'b1;
    @(negedge clock);
    total++; if (period_start !== 1'b1 || cnt_out !== 12'd1) begin
      bad++; $display("FAIL restart got ps=%b cnt=%0d want ps=1 cnt=1", period_start, cnt_out); end
    meas(f0, f1, r0, r1, len);
    total++; if (r0 != 500 || f1 != 0) begin bad++; $display("FAIL restart_old got=%0d,%0d want=500,0", r0, f1); end
    meas(f0, f1, r0, r1, len);
    total++; if (r0 != 500 || f1 != 300) begin bad++; $display("FAIL restart_pend got=%0d,%0d want=500,300", r0, f1); end
  endtask

  task automatic test_reset_pending();
    bit ok; int f0, f1, r0, r1, len;
    repeat (200) @(negedge clock);
    do_load(2'b01, 777, 0, 2'b00);
    reset = 1'b1; load = 2'b10; duty_in = {12'd888, 12'd777};
    @(negedge clock);
    reset = 1'b0; load = '0;
    total++; if ({pwm_fwd, pwm_rev, period_start} !== 5'b0 || cnt_out !== 12'd0) begin
      bad++; $display("FAIL rst_mid got=%b cnt=%0d want=0", {pwm_fwd, pwm_rev, period_start}, cnt_out); end
    sync_ps(ok);
    for (int p = 0; p < 2; p++) begin
      meas(f0, f1, r0, r1, len);
      total++; if (f0 + f1 + r0 + r1 != 0) begin
        bad++; $display("FAIL rst_lost got=%0d,%0d,%0d,%0d want=0", f0, f1, r0, r1); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 8000; i++) begin
      for (int k = 0; k < 2; k++) begin
        load[k] = ($urandom_range(0, 99) == 0);
        case ($urandom_range(0, 3))
          0: duty_in[k*12 +: 12] = 12'd0;
          1: duty_in[k*12 +: 12] = 12'($urandom_range(1000, 4095));
          default: duty_in[k*12 +: 12] = 12'($urandom_range(0, 999));
        endcase
        dir_in[k] = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 1999) == 0) activ = ~activ;
      else if (!activ && $urandom_range(0, 19) == 0) activ = 1'b1;
      reset = ($urandom_range(0, 4999) == 0);
      @(negedge clock);
    end
    load = '0; reset = 1'b0;
  endtask

`ifdef PWM_SOFT_START_EN
  task automatic test_soft_start();
    bit ok; int f0, f1, r0, r1, len;
    int up[6]  = '{8, 16, 24, 32, 40, 40};
    int dnf[10] = '{32, 24, 16, 8, 0, 0, 0, 0, 0, 0};
    int dnr[10] = '{0, 0, 0, 0, 0, 8, 16, 24, 32, 40};
    activ = 1'b1;
    do_load(2'b11, 40, 40, 2'b00);
    sync_ps(ok);
    for (int p = 0; p < 6; p++) begin
      meas(f0, f1, r0, r1, len);
      total++; if (f0 != up[p] || f1 != up[p]) begin bad++; $display("FAIL ramp_up[%0d] got=%0d,%0d want=%0d", p, f0, f1, up[p]); end
    end
    do_load(2'b01, 40, 40, 2'b01);
    sync_ps(ok);
    for (int p = 0; p < 10; p++) begin
      meas(f0, f1, r0, r1, len);
      total++; if (f0 != dnf[p] || r0 != dnr[p]) begin
        bad++; $display("FAIL ramp_dir[%0d] got=%0d/%0d want=%0d/%0d", p, f0, r0, dnf[p], dnr[p]); end
    end
  endtask
`endif

  initial begin
    @(negedge clock);
    test_reset();
`ifdef PWM_SOFT_START_EN
    test_soft_start();
`else
    test_duty_250();
    test_mid_load();
    test_extremes();
    test_dir_toggle();
    test_activ_drop();
    test_reset_pending();
    test_random();
`endif
    mon_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
